// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity serial transmitter.
// Frame: start, DATA_W data bits LSB first, parity, stop.
package odd_parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic int frame_len(input int data_w, input int baud_div);
        return (data_w + 3) * baud_div;
    endfunction

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator.
// Ones in {data, parity} always total an odd count.
module odd_parity_gen #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = ~^data;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter with valid/ready input and
// a parallel copy of the accepted word for loopback checking.
module odd_parity_serial_tx
    import odd_parity_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int BAUD_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_o,
    output logic              busy,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_p,
    output logic              frame_valid
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [CW-1:0]     baud_cnt;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              par_reg;
    logic              in_par;
    logic              tick;
    logic              accept;
    logic              last_bit;

    odd_parity_gen #(
        .DATA_W(DATA_W)
    ) u_gen (
        .data  (in_data),
        .parity(in_par)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign tick      = (baud_cnt == CW'(BAUD_DIV - 1));
    assign last_bit  = (bit_idx == IW'(DATA_W - 1));
    assign shift_nxt = shift_reg >> 1;

    // Counter is parked at zero in IDLE so START gets a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (state == IDLE || tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_o       <= 1'b1;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_reg    <= 1'b0;
            frame_data <= '0;
            frame_p    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= START;
                        tx_o       <= 1'b0;
                        shift_reg  <= in_data;
                        par_reg    <= in_par;
                        frame_data <= in_data;
                        frame_p    <= in_par;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_o    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_nxt;
                        if (last_bit) begin
                            state <= PARITY;
                            tx_o  <= par_reg;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_o    <= shift_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: BAUD_DIV=1 and BAUD_DIV=3 instances,
// a deserializing monitor per instance, and a word scoreboard.
module tb_odd_parity_serial_tx;
    import odd_parity_pkg::*;

    typedef struct {
        logic [3:0] data;
        logic       exp_p;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data[2];
    logic       in_valid[2];
    logic       in_ready[2];
    logic       tx[2];
    logic       busy[2];
    logic [3:0] fd[2];
    logic       fp[2];
    logic       fv[2];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    odd_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .tx_o(tx[0]), .busy(busy[0]),
        .frame_data(fd[0]), .frame_p(fp[0]), .frame_valid(fv[0])
    );

    odd_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .tx_o(tx[1]), .busy(busy[1]),
        .frame_data(fd[1]), .frame_p(fp[1]), .frame_valid(fv[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input int idx, input logic [3:0] w);
        if (idx == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    task automatic send(input int idx, input logic [3:0] w,
                        input bit hold, output int acc);
        int n = 0;
        @(negedge clk);
        in_data[idx]  = w;
        in_valid[idx] = 1'b1;
        while (!in_ready[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[idx]) begin
            timeout("send");
            in_valid[idx] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        push(idx, w);
        #1;
        acc = cyc;
        if (!hold) in_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx);
        int n = 0;
        @(negedge clk);
        while (busy[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy[idx]) timeout("wait_idle");
    endtask

    // Recovers each frame from the line, checks bit hold time,
    // framing, parity and the scoreboard word.
    task automatic monitor(input int idx);
        int   bd;
        int   fl;
        logic bits[7];
        logic glitch;
        logic aborted;
        logic [3:0] word;
        logic [3:0] exp_w;
        int   ones;
        bd = (idx == 0) ? 1 : 3;
        fl = frame_len(4, bd);
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && fv[idx]) begin
                glitch  = 1'b0;
                aborted = 1'b0;
                for (int k = 0; k < fl; k++) begin
                    if (k > 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % bd == 0) bits[k / bd] = tx[idx];
                    else if (tx[idx] !== bits[k / bd]) glitch = 1'b1;
                end
                if (aborted) begin
                    if (idx == 0 && q0.size() > 0) void'(q0.pop_front());
                    if (idx == 1 && q1.size() > 0) void'(q1.pop_front());
                end else begin
                    word = {bits[4], bits[3], bits[2], bits[1]};
                    ones = 0;
                    for (int i = 0; i < 4; i++) ones += int'(word[i]);
                    exp_w = 4'hx;
                    if (idx == 0 && q0.size() > 0) exp_w = q0.pop_front();
                    if (idx == 1 && q1.size() > 0) exp_w = q1.pop_front();
                    chk("mon_start", bits[0], 1'b0);
                    chk("mon_word", word, exp_w);
                    chk("mon_parity", bits[5], (ones % 2 == 0));
                    chk("mon_stop", bits[6], 1'b1);
                    chk("mon_hold", glitch, 1'b0);
                    chk("loop_err", ^{word, bits[5]} == 1'b0, 1'b0);
                    @(posedge clk);
                    #1;
                    chk("mon_busy_end", busy[idx], 1'b0);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        vec_t vecs[7];
        int   t1;
        int   t2;
        int   n;
        int   acc;

        vecs[0] = '{4'b0101, 1'b1};
        vecs[1] = '{4'b0111, 1'b0};
        vecs[2] = '{4'b1001, 1'b1};
        vecs[3] = '{4'b0001, 1'b0};
        vecs[4] = '{4'b1110, 1'b0};
        vecs[5] = '{4'b0000, 1'b1};
        vecs[6] = '{4'b1111, 1'b1};

        for (int i = 0; i < 2; i++) begin
            in_data[i]  = 4'h0;
            in_valid[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", tx[i], 1'b1);
            chk("rst_ready", in_ready[i], 1'b1);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_fdata", fd[i], 4'h0);
            chk("rst_fp", fp[i], 1'b1);
            chk("rst_fvalid", fv[i], 1'b0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send(0, vecs[i].data, 1'b0, acc);
            chk("tbl_fvalid", fv[0], 1'b1);
            chk("tbl_fdata", fd[0], vecs[i].data);
            chk("tbl_fp", fp[0], vecs[i].exp_p);
            chk("tbl_start", tx[0], 1'b0);
            chk("tbl_busy", busy[0], 1'b1);
            @(posedge clk);
            #1;
            chk("tbl_fv_pulse", fv[0], 1'b0);
            chk("tbl_d0", tx[0], vecs[i].data[0]);
            wait_idle(0);
        end

        send(1, 4'b1001, 1'b0, acc);
        chk("bd3_fp", fp[1], 1'b1);
        n = 0;
        while (busy[1] && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("bd3_busy_len", n, 21);
        wait_idle(1);

        send(0, 4'b0001, 1'b1, t1);
        in_data[0] = 4'b1110;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mid_fdata", fd[0], 4'b0001);
        chk("mid_fvalid", fv[0], 1'b0);
        chk("mid_ready", in_ready[0], 1'b0);
        n = 0;
        @(negedge clk);
        while (!in_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hs_ready_at", cyc - t1, 7);
        chk("hs_idle_tx", tx[0], 1'b1);
        chk("hs_idle_busy", busy[0], 1'b0);
        @(posedge clk);
        push(0, 4'b1110);
        #1;
        t2 = cyc;
        in_valid[0] = 1'b0;
        chk("hs_gap", t2 - t1, 8);
        chk("hs_fdata", fd[0], 4'b1110);
        wait_idle(0);

        send(0, 4'b1011, 1'b0, acc);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx[0], 1'b1);
        chk("rst_mid_busy", busy[0], 1'b0);
        chk("rst_mid_ready", in_ready[0], 1'b1);
        repeat (2) @(negedge clk);
        in_data[0]  = 4'b1100;
        in_valid[0] = 1'b1;
        rst_n = 1'b1;
        chk("rst_rel_ready", in_ready[0], 1'b1);
        @(posedge clk);
        push(0, 4'b1100);
        #1;
        in_valid[0] = 1'b0;
        chk("rst_rel_fv", fv[0], 1'b1);
        chk("rst_rel_fdata", fd[0], 4'b1100);
        wait_idle(0);

        for (int w = 0; w < 16; w++) begin
            send(0, 4'(w), 1'b1, acc);
        end
        in_valid[0] = 1'b0;
        wait_idle(0);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_q0_empty", q0.size(), 0);
        chk("sb_q1_empty", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
